// File: rtl/bw_arb_pkg.sv
// Shared types for the credit arbiter: per-channel accounts, pick results and
// the pairwise comparison that the pick tree is built from.
package bw_arb_pkg;

    // Fields are sized for the widest supported arbiter (16 channels, 16-bit balances)
    localparam int ID_W  = 4;
    localparam int AMT_W = 16;

    typedef struct packed {
        logic [AMT_W-1:0] balance;
        logic [ID_W-1:0]  id;
    } acct_t;

    typedef struct packed {
        logic [AMT_W-1:0] amount;
        logic [ID_W-1:0]  id;
        logic             valid;
    } win_t;

    function automatic win_t best_of(input win_t a, input win_t b);
        if (a.valid != b.valid) return a.valid ? a : b;
        if (a.amount != b.amount) return (a.amount > b.amount) ? a : b;
        return (a.id <= b.id) ? a : b;
    endfunction

endpackage

// File: rtl/bw_arb_pick.sv
// Combinational max-balance picker: a balanced tree of best_of over N accounts,
// masked by eligibility. Ties resolve to the lowest channel index.
module bw_arb_pick
    import bw_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  acct_t [N-1:0] accts_i,
    input  logic  [N-1:0] elig_i,
    output win_t          win_o
);

    localparam int LVLS = (N > 1) ? $clog2(N) : 1;
    localparam int P    = 1 << LVLS;

    for (genvar gi = 0; gi <= LVLS; gi++) begin : g_lvl
        win_t w [P >> gi];
        if (gi == 0) begin : g_leaf
            for (genvar gj = 0; gj < P; gj++) begin : g_in
                if (gj < N) begin : g_real
                    assign w[gj] = '{amount: accts_i[gj].balance, id: accts_i[gj].id, valid: elig_i[gj]};
                end else begin : g_pad
                    assign w[gj] = '0;
                end
            end
        end else begin : g_node
            for (genvar gj = 0; gj < (P >> gi); gj++) begin : g_cmp
                assign w[gj] = best_of(g_lvl[gi-1].w[2*gj], g_lvl[gi-1].w[2*gj+1]);
            end
        end
    end

    assign win_o = g_lvl[LVLS].w[0];

endmodule

// File: rtl/bw_credit_arb.sv
// N-channel credit arbiter: highest balance wins and pays one credit per grant,
// with burst hold, periodic weighted refill and a round-robin fallback.
module bw_credit_arb
    import bw_arb_pkg::*;
#(
    parameter int N             = 4,
    parameter int BW            = 8,
    parameter int CAP           = 255,
    parameter int REFILL_PERIOD = 64,
    parameter int MAX_BURST     = 4,
    parameter int WORK_CONSERVE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N*BW-1:0]      weight,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 grant_valid,
    output logic                 grant_credit,
    output logic                 refill_pulse
);

    localparam int IW  = $clog2(N);
    localparam int CW  = $clog2(REFILL_PERIOD);
    localparam int BCW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    logic [BW-1:0]  bal_q [N];
    logic [BW-1:0]  bal_d [N];
    logic [CW-1:0]  refill_cnt_q;
    logic [BCW-1:0] burst_cnt_q, burst_cnt_d;
    logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [IW-1:0]  grant_id_q, grant_id_d;
    logic           grant_credit_q, grant_credit_d;
    logic           refill_pulse_q;

    logic           refill;
    logic [N-1:0]   elig, chg;
    acct_t [N-1:0]  accts;
    win_t           credit_win;
    logic           hold;
    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    logic [IW-1:0]  rr_off, rr_win;
    logic [IW:0]    rr_sum;
    logic           unused_win;

    assign refill = (refill_cnt_q == '0);

    for (genvar gi = 0; gi < N; gi++) begin : g_chan
        logic [BW:0] dec_w, sum_w;
        assign elig[gi]  = req[gi] && (bal_q[gi] != '0);
        assign accts[gi] = '{balance: AMT_W'(bal_q[gi]), id: ID_W'(gi)};
        // Charge and refill combine before saturation so a full balance still pays
        assign dec_w     = {1'b0, bal_q[gi]} - {{BW{1'b0}}, chg[gi]};
        assign sum_w     = dec_w + {1'b0, weight[gi*BW +: BW]};
        assign bal_d[gi] = !refill ? dec_w[BW-1:0]
                         : (sum_w > (BW+1)'(CAP)) ? BW'(CAP) : sum_w[BW-1:0];
    end

    bw_arb_pick #(.N(N)) u_pick (
        .accts_i (accts),
        .elig_i  (elig),
        .win_o   (credit_win)
    );

    assign unused_win = ^{credit_win.amount, credit_win.id};

    // Rotate so rr_ptr sits at bit 0, then take the lowest set bit
    assign req_dbl = {req, req};
    assign req_rot = req_dbl[rr_ptr_q +: N];

    always_comb begin
        rr_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) rr_off = IW'(i);
        end
        rr_sum = {1'b0, rr_ptr_q} + {1'b0, rr_off};
        if (rr_sum >= (IW+1)'(N)) rr_sum = rr_sum - (IW+1)'(N);
        rr_win = rr_sum[IW-1:0];
    end

    assign hold = grant_q[grant_id_q] && req[grant_id_q]
               && (burst_cnt_q < BCW'(MAX_BURST - 1)) && (bal_q[grant_id_q] != '0);

    always_comb begin
        grant_d        = '0;
        grant_id_d     = '0;
        grant_credit_d = 1'b0;
        burst_cnt_d    = '0;
        rr_ptr_d       = rr_ptr_q;
        chg            = '0;
        if (hold) begin
            grant_d[grant_id_q] = 1'b1;
            grant_id_d          = grant_id_q;
            grant_credit_d      = 1'b1;
            burst_cnt_d         = burst_cnt_q + BCW'(1);
            chg[grant_id_q]     = 1'b1;
        end else if (credit_win.valid) begin
            grant_d[credit_win.id[IW-1:0]] = 1'b1;
            grant_id_d                     = credit_win.id[IW-1:0];
            grant_credit_d                 = 1'b1;
            chg[credit_win.id[IW-1:0]]     = 1'b1;
        end else if ((WORK_CONSERVE != 0) && (req != '0)) begin
            grant_d[rr_win] = 1'b1;
            grant_id_d      = rr_win;
            rr_ptr_d        = (rr_win == IW'(N - 1)) ? '0 : rr_win + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) bal_q[i] <= '0;
            refill_cnt_q   <= '0;
            burst_cnt_q    <= '0;
            rr_ptr_q       <= '0;
            grant_q        <= '0;
            grant_id_q     <= '0;
            grant_credit_q <= 1'b0;
            refill_pulse_q <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) bal_q[i] <= bal_d[i];
            refill_cnt_q   <= (refill_cnt_q == CW'(REFILL_PERIOD - 1)) ? '0 : refill_cnt_q + CW'(1);
            burst_cnt_q    <= burst_cnt_d;
            rr_ptr_q       <= rr_ptr_d;
            grant_q        <= grant_d;
            grant_id_q     <= grant_id_d;
            grant_credit_q <= grant_credit_d;
            refill_pulse_q <= refill;
        end
    end

    assign grant        = grant_q;
    assign grant_id     = grant_id_q;
    assign grant_valid  = |grant_q;
    assign grant_credit = grant_credit_q;
    assign refill_pulse = refill_pulse_q;

endmodule

// File: tb/tb_bw_credit_arb.sv
// Directed bench for bw_credit_arb (N=4, BW=8, CAP=255, period 64, burst 4):
// edge numbers below count rising edges after reset release, edge 1 being the first refill.
module tb_bw_credit_arb;

    localparam int N  = 4;
    localparam int BW = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*BW-1:0] weight = '0;
    logic [N-1:0]    grant;
    logic [1:0]      grant_id;
    logic            grant_valid, grant_credit, refill_pulse;

    int n_vec  = 0;
    int n_miss = 0;

    bw_credit_arb #(
        .N(N), .BW(BW), .CAP(255), .REFILL_PERIOD(64), .MAX_BURST(4), .WORK_CONSERVE(1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .weight       (weight),
        .grant        (grant),
        .grant_id     (grant_id),
        .grant_valid  (grant_valid),
        .grant_credit (grant_credit),
        .refill_pulse (refill_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // ch < 0 means idle
    task automatic expect_gnt(input string tag, input int ch, input logic cred);
        chk({tag, ".grant"}, 32'(grant), (ch < 0) ? 32'd0 : (32'd1 << ch));
        chk({tag, ".id"}, 32'(grant_id), (ch < 0) ? 32'd0 : 32'(ch));
        chk({tag, ".valid"}, 32'(grant_valid), (ch < 0) ? 32'd0 : 32'd1);
        chk({tag, ".credit"}, 32'(grant_credit), 32'(cred));
    endtask

    // Leaves the bench at the falling edge just after edge 1 (the first refill)
    task automatic do_reset(input logic [N*BW-1:0] w, input logic [N-1:0] r);
        cyc();
        reset = 1'b0;
        req = '0;
        cyc();
        expect_gnt("rst", -1, 1'b0);
        chk("rst.refill_pulse", 32'(refill_pulse), 32'd0);
        weight = w;
        req = r;
        reset = 1'b1;
        cyc();
        chk("rst.first_refill", 32'(refill_pulse), 32'd1);
    endtask

    initial begin
        // Weights {100,50,50,50}, all requesting: channel 0 keeps winning on credit
        do_reset({8'd50, 8'd50, 8'd50, 8'd100}, 4'b0000);
        expect_gnt("t1.idle", -1, 1'b0);
        req = 4'b1111;
        for (int e = 2; e <= 19; e++) begin
            cyc();
            expect_gnt($sformatf("t1.e%0d", e), 0, 1'b1);
        end

        // Async reset mid-burst drops the grant before the next edge
        #2 reset = 1'b0;
        #1 expect_gnt("async.drop", -1, 1'b0);
        cyc();
        reset = 1'b1;
        cyc();
        // Balances are zero at the first edge, so the grant is a fallback one
        expect_gnt("async.first", 0, 1'b0);
        chk("async.refill_pulse", 32'(refill_pulse), 32'd1);

        // Tie between channels 1 and 3 goes to 1; after its burst 3 (50) beats 1 (46)
        do_reset({8'd50, 8'd50, 8'd50, 8'd50}, 4'b0000);
        req = 4'b1010;
        for (int e = 2; e <= 10; e++) begin
            cyc();
            expect_gnt($sformatf("t2.e%0d", e), (e <= 5) ? 1 : (e <= 9) ? 3 : 1, 1'b1);
        end

        // Starvation: 2 credits for channel 0, then round-robin until the refill at edge 65
        do_reset({8'd0, 8'd0, 8'd0, 8'd2}, 4'b0000);
        req = 4'b0011;
        for (int e = 2; e <= 68; e++) begin
            cyc();
            if (e <= 3 || e == 66 || e == 67)
                expect_gnt($sformatf("t3.e%0d", e), 0, 1'b1);
            else if (e <= 65)
                expect_gnt($sformatf("t3.e%0d", e), (e - 4) % 2, 1'b0);
            else
                expect_gnt($sformatf("t3.e%0d", e), 0, 1'b0);
            chk($sformatf("t3.pulse%0d", e), 32'(refill_pulse), (e == 65) ? 32'd1 : 32'd0);
        end

        // Saturation: three refills of 200 must leave exactly 255, drained one per cycle
        do_reset({8'd0, 8'd0, 8'd0, 8'd200}, 4'b0000);
        for (int e = 2; e <= 129; e++) begin
            cyc();
            chk($sformatf("t4.pulse%0d", e), 32'(refill_pulse), ((e - 1) % 64 == 0) ? 32'd1 : 32'd0);
        end
        chk("t4.idle", 32'(grant_valid), 32'd0);
        weight = '0;
        req = 4'b0001;
        for (int e = 130; e <= 385; e++) begin
            cyc();
            chk($sformatf("t4.grant%0d", e), 32'(grant), 32'd1);
            chk($sformatf("t4.credit%0d", e), 32'(grant_credit), (e <= 384) ? 32'd1 : 32'd0);
        end

        // Hold break and single-cycle request on channel 2
        do_reset({8'd0, 8'd50, 8'd0, 8'd0}, 4'b0000);
        req = 4'b0100;
        cyc(); expect_gnt("t5.e2", 2, 1'b1);
        cyc(); expect_gnt("t5.e3", 2, 1'b1);
        req = 4'b0000;
        cyc(); expect_gnt("t5.e4", -1, 1'b0);
        req = 4'b0100;
        for (int e = 5; e <= 9; e++) begin
            cyc();
            expect_gnt($sformatf("t5.e%0d", e), 2, 1'b1);
        end
        req = 4'b0000;
        cyc(); expect_gnt("t5.e10", -1, 1'b0);
        req = 4'b0100;
        cyc(); expect_gnt("t5.single", 2, 1'b1);
        req = 4'b0000;
        cyc(); expect_gnt("t5.after", -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/bw_credit_arb.md
Name: bw_credit_arb

Overview:
- N-channel bandwidth arbiter; successor to the fixed 4-port priority/balance arbiter.
- Each channel holds a credit balance. The highest-balance requester wins, and each granted cycle costs 1 credit.
- Balances are replenished by per-channel weights every REFILL_PERIOD cycles.
- Adds burst hold and a work-conserving round-robin fallback. Sits in front of a shared bus/memory port.

Parameters:
- N, 4, number of requesters (2..16).
- BW, 8, balance/weight width in bits.
- CAP, 255, balance saturation ceiling (must be < 2**BW).
- REFILL_PERIOD, 64, cycles between refills (>=2).
- MAX_BURST, 4, max consecutive cycles one grantee may hold (1 = no hold).
- WORK_CONSERVE, 1, 1 = round-robin fallback when no requester has credit; 0 = idle.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  N  per-channel request level.
- weight  input  N*BW  per-channel refill amount; channel i occupies bits [i*BW +: BW]; sampled only on refill cycles.
- grant  output  N  registered one-hot grant (all-zero = idle).
- grant_id  output  $clog2(N)  index of the current grantee; 0 when idle.
- grant_valid  output  1  OR of grant.
- grant_credit  output  1  1 = current grant won on credit; 0 = fallback grant.
- refill_pulse  output  1  registered; high for the cycle after a refill is applied.

Behaviour:
- Reset (reset low, async) sets:
  - grant=0, grant_id=0, grant_valid=0, grant_credit=0, refill_pulse=0;
  - all balances=0, refill_cnt=0, burst_cnt=0, rr_ptr=0.
- Refill:
  - A refill occurs on every cycle where refill_cnt==0.
  - refill_cnt counts 0..REFILL_PERIOD-1, then wraps to 0.
  - The first refill is the first clock edge after reset deasserts.
  - On refill: bal_i <= min(bal_i - chg_i + weight_i, CAP), computed at BW+1 bits. chg_i=1 if channel i is charged that cycle, else 0.
- Decision uses current req and registered state. Grant is registered: req sampled at edge k appears on grant after edge k+1 (1-cycle latency).
- Hold check:
  - If grant[g]==1, req[g]==1, burst_cnt<MAX_BURST-1 and bal_g>0, then g is granted again with credit and burst_cnt increments.
  - Otherwise run normal arbitration and set burst_cnt <= 0.
- Credit pass:
  - Eligible = req_i && bal_i>0.
  - Winner is the highest balance; ties go to the lowest index.
  - grant_credit=1; the winner is charged 1 (chg=1).
- Fallback pass:
  - Runs only if no channel is eligible, WORK_CONSERVE==1 and req!=0.
  - Winner is the first requester at or after rr_ptr (circular); then rr_ptr <= winner+1 mod N.
  - grant_credit=0; no charge.
  - rr_ptr changes only on fallback grants.
- req==0, or no eligible channel with WORK_CONSERVE==0: grant=0 next cycle; burst_cnt <= 0.
- Balances never underflow, since only bal>0 channels are charged, and never exceed CAP.
- A charge to bal=1 with no refill that cycle leaves 0.
- weight_i=0 is legal; that channel is served only by the fallback pass.
- Reset mid-burst or mid-refill-period discards all credit and counters immediately.

Decomposition:
- Package bw_arb_pkg holds:
  - typedef acct_t {logic [BW-1:0] balance; logic [$clog2(N)-1:0] id;};
  - typedef win_t {logic [BW-1:0] amount; logic [$clog2(N)-1:0] id; logic valid;};
  - the function best_of(win_t a, win_t b), which prefers valid, then greater amount, then lower id.
- One sub-module, bw_arb_pick: combinational tree of best_of over N acct_t with an eligible mask; outputs win_t. It is reused for the credit pass.
- Fallback uses a rotate-and-priority-encode inside the top module.

Test Plan (N=4, BW=8, CAP=255, REFILL_PERIOD=64, MAX_BURST=4, WORK_CONSERVE=1, weights {100,50,50,50}):
- Reset, then req=4'b1111 held 16 cycles -> channel 0 granted cycles 1-4 (hold), burst ends, channel 0 (bal 96) wins again, then hold; balances after 16 grants: {84,50,50,50}; grant_credit=1 throughout.
- Tie check: weights {50,50,50,50}, req=4'b1010 -> first grant is channel 1 (lower index); held 4 cycles, then channel 3 (bal 50 > 46).
- Starvation/fallback: weights {2,0,0,0}, req=4'b0011 -> channel 0 granted 2 cycles with grant_credit=1, then fallback grants 1,0,1,0... with grant_credit=0 until the refill at cycle 64; then channel 0 regains credit for 2 cycles.
- Saturation: weights {200,0,0,0}, req=0 for 3 refills -> bal0 =255 (not 600); refill_pulse high 3 times at 64-cycle spacing.
- Hold break: channel 2 granted in burst, req[2] drops after 2 cycles -> grant=0 next cycle (or the next winner), burst_cnt restarts; a single-cycle req gives exactly 1 grant cycle, 1 cycle late.
- Async reset asserted mid-burst (between edges) -> grant/grant_valid drop to 0 immediately; after release, all balances are 0 until the first refill edge.
